// File: rtl/code_lock_pkg.sv
// Shared definitions for the multi-digit code lock: state encoding and a width helper.
package code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    // Bits needed to hold values 0..value-1 (callers pass max+1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/code_lock_fsm_cycle_timer.sv
// Load / decrement / zero-flag down-counter used for the door, lockout and entry timers.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Multi-digit access-code lock: collects DIGITS keypad digits, opens the door or counts a failure.
// Optional ENTRY_TIMEOUT_EN macro adds an inactivity timeout during code entry.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int                       CODE_W         = 4,
    parameter int                       DIGITS         = 4,
    parameter logic [DIGITS*CODE_W-1:0] CODE           = 16'h9371,
    parameter int                       MAX_FAILS      = 3,
    parameter int                       OPEN_CYCLES    = 8,
    parameter int                       LOCK_CYCLES    = 16,
    parameter int                       TIMEOUT_CYCLES = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             digit_valid,
    input  logic [CODE_W-1:0]                digit,
    input  logic                             clear,
    output logic                             digit_ready,
    output logic                             open_access_door,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [2:0]                       state_out
);

    localparam int FAIL_W   = clog2(MAX_FAILS + 1);
    localparam int IDX_W    = clog2(DIGITS + 1);
    localparam int HOLD_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int HOLD_W   = clog2(HOLD_MAX + 1);

    lock_state_t       state;
    lock_state_t       state_next;
    logic [IDX_W-1:0]  idx;
    logic              mismatch;
    logic [CODE_W-1:0] expected_digit;
    logic              accept;
    logic              last_digit;
    logic              digit_miss;
    logic              fail_sat;
    logic              fail_event;
    logic              timeout_expired;
    logic              hold_load;
    logic              hold_zero;
    logic [HOLD_W-1:0] hold_value;

    // Keypad handshake: a digit transfers on a cycle where digit_valid and digit_ready are both
    // high and clear is low; digit_ready depends only on the registered state.
    assign accept         = digit_valid && digit_ready && !clear;
    assign expected_digit = CODE_W'(CODE >> (CODE_W * (DIGITS - 1 - int'(idx))));
    assign digit_miss     = (digit != expected_digit);
    assign last_digit     = (idx == IDX_W'(DIGITS - 1));
    assign fail_sat       = (int'(fail_count) + 1) >= MAX_FAILS;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);
    logic entry_zero;

    // Reloaded by every accepted digit, counts down only while waiting in ENTRY.
    cycle_timer #(
        .WIDTH(TO_W)
    ) u_entry_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (TO_W'(TIMEOUT_CYCLES - 1)),
        .dec        (state == ENTRY),
        .zero       (entry_zero)
    );

    assign timeout_expired = (state == ENTRY) && !clear && !accept && entry_zero;
`else
    logic timeout_unused;
    assign timeout_unused  = (TIMEOUT_CYCLES != 0);
    assign timeout_expired = 1'b0;
`endif

    assign fail_event = ((state == CHECK) && mismatch) || timeout_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = last_digit ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (clear) begin
                    state_next = IDLE;
                end else if (accept && last_digit) begin
                    state_next = CHECK;
                end else if (timeout_expired) begin
                    state_next = fail_sat ? LOCKOUT : IDLE;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    state_next = fail_sat ? LOCKOUT : IDLE;
                end else begin
                    state_next = OPEN;
                end
            end
            OPEN, LOCKOUT: begin
                if (hold_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        digit_ready      = (state == IDLE) || (state == ENTRY);
        open_access_door = (state == OPEN);
        locked_out       = (state == LOCKOUT);
        state_out        = state;
    end

    // Loaded with duration-1 on entry so the state lasts exactly the full duration.
    assign hold_load  = (state_next != state) &&
                        ((state_next == OPEN) || (state_next == LOCKOUT));
    assign hold_value = (state_next == OPEN) ? HOLD_W'(OPEN_CYCLES - 1)
                                             : HOLD_W'(LOCK_CYCLES - 1);

    cycle_timer #(
        .WIDTH(HOLD_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (hold_value),
        .dec        ((state == OPEN) || (state == LOCKOUT)),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            mismatch   <= 1'b0;
            fail_count <= '0;
        end else begin
            if (state_next == IDLE) begin
                idx      <= '0;
                mismatch <= 1'b0;
            end else if (accept) begin
                idx      <= idx + 1'b1;
                mismatch <= mismatch | digit_miss;
            end

            if (fail_event) begin
                fail_count <= fail_sat ? FAIL_W'(MAX_FAILS) : fail_count + 1'b1;
            end else if ((state == CHECK) && !mismatch) begin
                fail_count <= '0;
            end else if ((state == LOCKOUT) && (state_next == IDLE)) begin
                fail_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: cycle-count model of the lock, scoreboard compare at negedge, directed tests.
module tb_code_lock_fsm;

    localparam int          CODE_W         = 4;
    localparam int          DIGITS         = 4;
    localparam logic [15:0] CODE           = 16'h9371;
    localparam int          MAX_FAILS      = 3;
    localparam int          OPEN_CYCLES    = 8;
    localparam int          LOCK_CYCLES    = 16;
    localparam int          TIMEOUT_CYCLES = 10;
    localparam int          FW             = 2;
    localparam int          EW             = 6 + FW;

    logic              clk;
    logic              rst;
    logic              digit_valid;
    logic [CODE_W-1:0] digit;
    logic              clear;
    logic              digit_ready;
    logic              open_access_door;
    logic              locked_out;
    logic [FW-1:0]     fail_count;
    logic [2:0]        state_out;

    code_lock_fsm #(
        .CODE_W(CODE_W), .DIGITS(DIGITS), .CODE(CODE), .MAX_FAILS(MAX_FAILS),
        .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .clear(clear),
        .digit_ready(digit_ready), .open_access_door(open_access_door),
        .locked_out(locked_out), .fail_count(fail_count), .state_out(state_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [EW-1:0] exp_q[$];

    // Model: time-stamped view of the lock (cycle of CHECK, end cycles of door/lockout)
    int cyc;
    int check_cyc;
    int open_end;
    int lock_end;
    int last_acc;
    int m_fails;
    int m_digits[$];

    int door_cycles;
    int lock_cycles_seen;
    logic [2:0] st_log[$];

    function automatic int exp_state();
        if (cyc == check_cyc) return 2;
        if (cyc < open_end) return 3;
        if (cyc < lock_end) return 4;
        if (m_digits.size() > 0) return 1;
        return 0;
    endfunction

    task automatic model_fail();
        if (m_fails + 1 >= MAX_FAILS) begin
            m_fails  = MAX_FAILS;
            lock_end = cyc + 1 + LOCK_CYCLES;
        end else begin
            m_fails++;
        end
    endtask

    task automatic model_push();
        int s;
        logic [EW-1:0] e;
        s = exp_state();
        e = {3'(s), (s <= 1), (s == 3), (s == 4), FW'(m_fails)};
        exp_q.push_back(e);
    endtask

    task automatic model_update(input logic v, input logic [3:0] d, input logic clr, input logic r);
        int s;
        int value;
        s = exp_state();
        if (r) begin
            m_digits.delete();
            m_fails   = 0;
            check_cyc = -1;
            open_end  = 0;
            lock_end  = 0;
        end else if (s == 2) begin
            value = 0;
            foreach (m_digits[i]) value = value * 16 + m_digits[i];
            m_digits.delete();
            if (value == int'(CODE)) begin
                m_fails  = 0;
                open_end = cyc + 1 + OPEN_CYCLES;
            end else begin
                model_fail();
            end
        end else if (s == 4) begin
            if (cyc == lock_end - 1) m_fails = 0;
        end else if (s <= 1) begin
            if (clr) begin
                m_digits.delete();
            end else if (v) begin
                m_digits.push_back(int'(d));
                last_acc = cyc;
                if (m_digits.size() == DIGITS) check_cyc = cyc + 1;
            end
`ifdef ENTRY_TIMEOUT_EN
            else if (s == 1 && (cyc - last_acc) == TIMEOUT_CYCLES) begin
                m_digits.delete();
                model_fail();
            end
`endif
        end
        cyc++;
    endtask

    // Scoreboard compare
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            st_log.push_back(state_out);
            if (open_access_door) door_cycles++;
            if (locked_out) lock_cycles_seen++;
            checks += 5;
            if (state_out !== e[7:5]) begin
                errors++;
                $display("FAIL state_out cyc=%0d got=%0d exp=%0d", cyc, state_out, e[7:5]);
            end
            if (digit_ready !== e[4]) begin
                errors++;
                $display("FAIL digit_ready cyc=%0d got=%0b exp=%0b", cyc, digit_ready, e[4]);
            end
            if (open_access_door !== e[3]) begin
                errors++;
                $display("FAIL open_access_door cyc=%0d got=%0b exp=%0b", cyc, open_access_door, e[3]);
            end
            if (locked_out !== e[2]) begin
                errors++;
                $display("FAIL locked_out cyc=%0d got=%0b exp=%0b", cyc, locked_out, e[2]);
            end
            if (fail_count !== e[1:0]) begin
                errors++;
                $display("FAIL fail_count cyc=%0d got=%0d exp=%0d", cyc, fail_count, e[1:0]);
            end
        end
    end

    task automatic check_lit(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, actual, expected);
        end
    endtask

    // Driver tasks
    task automatic cycle_in(input logic v, input logic [3:0] d, input logic clr, input logic r);
        digit_valid = v;
        digit       = d;
        clear       = clr;
        rst         = r;
        model_push();
        @(negedge clk);
        model_update(v, d, clr, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_in(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic send_code(input logic [15:0] c);
        for (int i = 0; i < DIGITS; i++) cycle_in(1'b1, c[15-4*i -: 4], 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        door_cycles      = 0;
        lock_cycles_seen = 0;
        st_log.delete();
    endtask

    initial begin
        logic [15:0] code_v;
        logic [3:0]  d;
        int          k;
        checks = 0;
        errors = 0;
        cyc = 0; check_cyc = -1; open_end = 0; lock_end = 0; last_acc = 0; m_fails = 0;
        rst = 1'b1; digit_valid = 1'b0; digit = '0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();
        cycle_in(1'b0, 4'h0, 1'b0, 1'b1);
        check_lit("reset_state", int'(state_out), 0);
        check_lit("reset_ready", int'(digit_ready), 1);

        // Correct code
        clear_counts();
        send_code(16'h9371);
        idle(12);
        check_lit("seq_d1", int'(st_log[1]), 1);
        check_lit("seq_d2", int'(st_log[2]), 1);
        check_lit("seq_d3", int'(st_log[3]), 1);
        check_lit("seq_check", int'(st_log[4]), 2);
        check_lit("seq_open", int'(st_log[5]), 3);
        check_lit("open_len", door_cycles, 8);
        check_lit("open_fail", int'(fail_count), 0);
        check_lit("open_done_state", int'(state_out), 0);

        // Wrong code
        clear_counts();
        send_code(16'h9372);
        idle(3);
        check_lit("wrong_d3_entry", int'(st_log[3]), 1);
        check_lit("wrong_check", int'(st_log[4]), 2);
        check_lit("wrong_door", door_cycles, 0);
        check_lit("wrong_fail", int'(fail_count), 1);

        // Lockout after three wrong codes; correct code during lockout ignored
        cycle_in(1'b0, 4'h0, 1'b0, 1'b1);
        clear_counts();
        send_code(16'h1111); idle(1);
        send_code(16'h9372); idle(1);
        check_lit("lock_fail2", int'(fail_count), 2);
        send_code(16'h0000); idle(1);
        check_lit("lock_sat", int'(fail_count), 3);
        send_code(16'h9371);
        idle(14);
        check_lit("lock_len", lock_cycles_seen, 16);
        check_lit("lock_door", door_cycles, 0);
        check_lit("lock_exit_fail", int'(fail_count), 0);
        check_lit("lock_exit_state", int'(state_out), 0);
        clear_counts();
        send_code(16'h9371);
        idle(10);
        check_lit("post_lock_open", door_cycles, 8);

        // Clear priority over digit_valid
        send_code(16'h5555); idle(1);
        clear_counts();
        cycle_in(1'b1, 4'h9, 1'b0, 1'b0);
        cycle_in(1'b1, 4'h3, 1'b0, 1'b0);
        cycle_in(1'b1, 4'h7, 1'b1, 1'b0);
        check_lit("clear_state", int'(state_out), 0);
        check_lit("clear_fail", int'(fail_count), 1);
        send_code(16'h9371);
        idle(10);
        check_lit("clear_then_open", door_cycles, 8);
        check_lit("clear_open_fail", int'(fail_count), 0);

        // Reset on the third OPEN cycle
        send_code(16'h9371);
        idle(3);
        check_lit("pre_reset_open", int'(open_access_door), 1);
        cycle_in(1'b0, 4'h0, 1'b0, 1'b1);
        check_lit("rst_open_door", int'(open_access_door), 0);
        check_lit("rst_open_state", int'(state_out), 0);
        check_lit("rst_open_fail", int'(fail_count), 0);

        // Entry inactivity
        cycle_in(1'b1, 4'h9, 1'b0, 1'b0);
        cycle_in(1'b1, 4'h3, 1'b0, 1'b0);
        idle(10);
`ifdef ENTRY_TIMEOUT_EN
        check_lit("timeout_state", int'(state_out), 0);
        check_lit("timeout_fail", int'(fail_count), 1);
`else
        check_lit("no_timeout_state", int'(state_out), 1);
        idle(40);
        check_lit("no_timeout_long", int'(state_out), 1);
        check_lit("no_timeout_fail", int'(fail_count), 0);
        cycle_in(1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // Mixed random traffic checked by the model
        code_v = CODE;
        for (int i = 0; i < 300; i++) begin
            k = m_digits.size();
            if (k < DIGITS && $urandom_range(0, 3) != 0) d = code_v[15-4*k -: 4];
            else d = 4'($urandom_range(0, 15));
            cycle_in(1'($urandom_range(0, 1)), d, ($urandom_range(0, 19) == 0), 1'b0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
